// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types for the memory-side arbiter: the cache line type, the
// arbiter FSM state encoding and the grant-side encoding.
package lc3b_types;

  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2,
    ARB_TURN = 2'd3
  } lc3b_arb_state;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } lc3b_arb_grant;

endpackage : lc3b_types

// File: rtl/arb_grant_sel.sv
// Next-grant selection for cache_arbiter. Purely combinational.
// Optional feature: CACHE_ARB_RR_EN -- when defined, a tie between I and D is
// broken in favour of the side not granted last; otherwise D always wins.
module arb_grant_sel
  import lc3b_types::*;
(
  input  logic          i_req_i,
  input  logic          i_req_d,
`ifdef CACHE_ARB_RR_EN
  input  lc3b_arb_grant i_last_grant,
`endif
  output logic          o_valid,
  output lc3b_arb_grant o_grant
);

  // Pick the winner among the pending requesters.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_valid = i_req_i | i_req_d;
    o_grant = GRANT_D;
`ifdef CACHE_ARB_RR_EN
    if (i_req_i && i_req_d) begin
      o_grant = (i_last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else begin
      o_grant = i_req_d ? GRANT_D : GRANT_I;
    end
`else
    o_grant = i_req_d ? GRANT_D : GRANT_I;
`endif
  end

endmodule : arb_grant_sel

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single physical-memory port between the I-cache
// and the D-cache. One line transaction is outstanding at a time; the
// memory-side request/address/data come only from registers latched at grant.
// Optional feature: CACHE_ARB_RR_EN -- alternating priority on ties via a
// last_grant register (reset to I). Undefined: fixed D-over-I priority.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  lc3b_arb_state     r_state;
  lc3b_arb_state     w_next_state;
  logic              r_pmem_read;
  logic              r_pmem_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;

  logic              w_d_pend;
  logic              w_sel_valid;
  lc3b_arb_grant     w_sel_grant;
  logic              w_grant_entry;
  logic              w_busy;

  assign w_d_pend      = d_pmem_read | d_pmem_write;
  assign w_grant_entry = (r_state == ARB_IDLE) && w_sel_valid;
  assign w_busy        = (r_state == ARB_I) || (r_state == ARB_D);

`ifdef CACHE_ARB_RR_EN
  lc3b_arb_grant r_last_grant;

  // Remember which side won the most recent grant for tie-breaking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= GRANT_I;
    end else if (w_grant_entry) begin
      r_last_grant <= w_sel_grant;
    end
  end
`endif

  arb_grant_sel u_grant_sel (
    .i_req_i      (i_pmem_read),
    .i_req_d      (w_d_pend),
`ifdef CACHE_ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .o_valid      (w_sel_valid),
    .o_grant      (w_sel_grant)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection and the per-side completion pulses.
  always_comb begin
    w_next_state = r_state;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_sel_valid) begin
          w_next_state = (w_sel_grant == GRANT_D) ? ARB_D : ARB_I;
        end
      end
      ARB_I: begin
        i_pmem_resp = pmem_resp;
        if (pmem_resp) w_next_state = ARB_TURN;
      end
      ARB_D: begin
        d_pmem_resp = pmem_resp;
        if (pmem_resp) w_next_state = ARB_TURN;
      end
      ARB_TURN: begin
        w_next_state = ARB_IDLE;
      end
      default: begin
        w_next_state = ARB_IDLE;
      end
    endcase
  end

  // Grant latch: capture the winner's transaction; drop the request on resp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant_entry) begin
      if (w_sel_grant == GRANT_D) begin
        // A simultaneous read+write from the D-cache is serviced as a write.
        r_pmem_write <= d_pmem_write;
        r_pmem_read  <= ~d_pmem_write;
        r_addr       <= d_pmem_address;
        r_wdata      <= d_pmem_wdata;
      end else begin
        r_pmem_write <= 1'b0;
        r_pmem_read  <= 1'b1;
        r_addr       <= i_pmem_address;
        r_wdata      <= '0;
      end
    end else if (w_busy && pmem_resp) begin
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end
  end

  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;

  // Read data is broadcast; each side qualifies it with its own resp.
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

`ifndef SYNTHESIS
  // A D-cache controller should never ask for a read and a write together.
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_pmem_read && d_pmem_write))
    else $warning("cache_arbiter: d_pmem_read and d_pmem_write both high, serviced as write");
`endif

endmodule : cache_arbiter

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter. The bench plays both caches and the
// memory. Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [127:0] Z  = 128'h0;
  localparam logic [127:0] LA = {4{32'h1111_AAAA}};
  localparam logic [127:0] LB = {4{32'h2222_BBBB}};
  localparam logic [127:0] LC = {4{32'h3333_CCCC}};
  localparam logic [127:0] LD = {4{32'h4444_DDDD}};
  localparam logic [127:0] LE = {4{32'h5555_EEEE}};
  localparam logic [127:0] WA5 = {16{8'hA5}};
  localparam logic [127:0] W5A = {16{8'h5A}};
  localparam logic [127:0] WC3 = {16{8'hC3}};

  cache_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         rst;
    logic         ir;
    logic [15:0]  ia;
    logic         dr;
    logic         dw;
    logic [15:0]  da;
    logic [127:0] dwd;
    logic         presp;
    logic [127:0] prd;
    logic         e_pr;
    logic         e_pw;
    logic [15:0]  e_pa;
    logic [127:0] e_pwd;
    logic         e_ir;
    logic         e_dr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic add(input string name, input logic r, input logic ir, input logic [15:0] ia,
                     input logic dr, input logic dw, input logic [15:0] da, input logic [127:0] dwd,
                     input logic presp, input logic [127:0] prd,
                     input logic epr, input logic epw, input logic [15:0] epa,
                     input logic [127:0] epwd, input logic eir, input logic edr);
    vec_t v;
    v.name = name; v.rst = r; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da;
    v.dwd = dwd; v.presp = presp; v.prd = prd; v.e_pr = epr; v.e_pw = epw; v.e_pa = epa;
    v.e_pwd = epwd; v.e_ir = eir; v.e_dr = edr;
    vecs.push_back(v);
  endtask

  // Control outputs packed as {pmem_read, pmem_write, pmem_address, i_resp, d_resp}.
  task automatic expect_out(input string name, input logic epr, input logic epw,
                            input logic [15:0] epa, input logic eir, input logic edr);
    #1;
    check(name, {pmem_read, pmem_write, pmem_address, i_pmem_resp, d_pmem_resp},
          {epr, epw, epa, eir, edr});
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  logic [15:0] pair2_pa;
  logic        pair2_i;

  initial begin
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;

    //   name                rst ir ia        dr dw da        dwd  rsp rdata  pr pw pa        pwd  ir dr
    add("rst_hold",          1, 1, 16'h0040, 1, 0, 16'h0100, Z,   0,  LA,    0, 0, 16'h0000, Z,   0, 0);
    add("rst_hold2",         1, 1, 16'h0040, 1, 0, 16'h0100, Z,   0,  LA,    0, 0, 16'h0000, Z,   0, 0);
    add("rst_release",       0, 1, 16'h0040, 1, 0, 16'h0100, Z,   0,  LA,    0, 0, 16'h0000, Z,   0, 0);
    add("first_grant_d",     0, 1, 16'h0040, 1, 0, 16'h0100, Z,   0,  LA,    1, 0, 16'h0100, Z,   0, 0);
    add("d_resp",            0, 1, 16'h0040, 1, 0, 16'h0100, Z,   1,  LB,    1, 0, 16'h0100, Z,   0, 1);
    add("turn_after_d",      0, 1, 16'h0040, 0, 0, 16'h0100, Z,   0,  LB,    0, 0, 16'h0100, Z,   0, 0);
    add("idle_i_pending",    0, 1, 16'h0040, 0, 0, 16'h0100, Z,   0,  LB,    0, 0, 16'h0100, Z,   0, 0);
    add("i_resp_lat1",       0, 1, 16'h0040, 0, 0, 16'h0100, Z,   1,  LC,    1, 0, 16'h0040, Z,   1, 0);
    add("turn_after_i",      0, 0, 16'h0040, 0, 0, 16'h0100, Z,   0,  LC,    0, 0, 16'h0040, Z,   0, 0);
    add("idle_quiet",        0, 0, 16'h0040, 0, 0, 16'h0100, Z,   0,  LC,    0, 0, 16'h0040, Z,   0, 0);
    add("lone_i_c0",         0, 1, 16'h1230, 0, 0, 16'h0100, Z,   0,  LA,    0, 0, 16'h0040, Z,   0, 0);
    add("lone_i_c1",         0, 1, 16'h1230, 0, 0, 16'h0100, Z,   0,  LA,    1, 0, 16'h1230, Z,   0, 0);
    add("lone_i_c2",         0, 1, 16'h1230, 0, 0, 16'h0100, Z,   0,  LA,    1, 0, 16'h1230, Z,   0, 0);
    add("lone_i_c3",         0, 1, 16'h1230, 0, 0, 16'h0100, Z,   0,  LA,    1, 0, 16'h1230, Z,   0, 0);
    add("lone_i_resp_c4",    0, 1, 16'h1230, 0, 0, 16'h0100, Z,   1,  LD,    1, 0, 16'h1230, Z,   1, 0);
    add("lone_i_turn",       0, 0, 16'h1230, 0, 0, 16'h0100, Z,   0,  LD,    0, 0, 16'h1230, Z,   0, 0);
    add("lone_i_idle",       0, 0, 16'h1230, 0, 0, 16'h0100, Z,   0,  LD,    0, 0, 16'h1230, Z,   0, 0);
    add("simul_idle",        0, 1, 16'h0040, 0, 1, 16'h8000, WA5, 0,  LA,    0, 0, 16'h1230, Z,   0, 0);
    add("simul_write_first", 0, 1, 16'h0040, 0, 1, 16'h8000, WA5, 0,  LA,    0, 1, 16'h8000, WA5, 0, 0);
    add("simul_write_resp",  0, 1, 16'h0040, 0, 1, 16'h8000, WA5, 1,  LB,    0, 1, 16'h8000, WA5, 0, 1);
    add("simul_turn",        0, 1, 16'h0040, 0, 0, 16'h8000, WA5, 0,  LB,    0, 0, 16'h8000, WA5, 0, 0);
    add("simul_idle2",       0, 1, 16'h0040, 0, 0, 16'h8000, WA5, 0,  LB,    0, 0, 16'h8000, WA5, 0, 0);
    add("simul_read_second", 0, 1, 16'h0040, 0, 0, 16'h8000, WA5, 0,  LB,    1, 0, 16'h0040, Z,   0, 0);
    add("simul_read_resp",   0, 1, 16'h0040, 0, 0, 16'h8000, WA5, 1,  LC,    1, 0, 16'h0040, Z,   1, 0);
    add("simul_turn2",       0, 0, 16'h0040, 0, 0, 16'h8000, WA5, 0,  LC,    0, 0, 16'h0040, Z,   0, 0);
    add("simul_idle3",       0, 0, 16'h0040, 0, 0, 16'h8000, WA5, 0,  LC,    0, 0, 16'h0040, Z,   0, 0);
    add("addr_idle",         0, 0, 16'h0040, 1, 0, 16'h2000, Z,   0,  LA,    0, 0, 16'h0040, Z,   0, 0);
    add("addr_hold",         0, 0, 16'h0040, 1, 0, 16'h3000, Z,   0,  LA,    1, 0, 16'h2000, Z,   0, 0);
    add("addr_hold_resp",    0, 0, 16'h0040, 1, 0, 16'h3000, Z,   1,  LD,    1, 0, 16'h2000, Z,   0, 1);
    add("addr_turn",         0, 0, 16'h0040, 0, 0, 16'h3000, Z,   0,  LD,    0, 0, 16'h2000, Z,   0, 0);
    add("addr_idle2",        0, 0, 16'h0040, 0, 0, 16'h3000, Z,   0,  LD,    0, 0, 16'h2000, Z,   0, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].rst;
      i_pmem_read = vecs[k].ir; i_pmem_address = vecs[k].ia;
      d_pmem_read = vecs[k].dr; d_pmem_write = vecs[k].dw;
      d_pmem_address = vecs[k].da; d_pmem_wdata = vecs[k].dwd;
      pmem_resp = vecs[k].presp; pmem_rdata = vecs[k].prd;
      expect_out(vecs[k].name, vecs[k].e_pr, vecs[k].e_pw, vecs[k].e_pa, vecs[k].e_ir, vecs[k].e_dr);
      check({vecs[k].name, "_wdata"}, pmem_wdata, vecs[k].e_pwd);
      check({vecs[k].name, "_i_rdata"}, i_pmem_rdata, vecs[k].prd);
      check({vecs[k].name, "_d_rdata"}, d_pmem_rdata, vecs[k].prd);
    end

    // Reset in the middle of a granted D write abandons it without a resp.
    nxt();
    d_pmem_write = 1'b1; d_pmem_address = 16'h4000; d_pmem_wdata = W5A;
    expect_out("rstmid_idle", 0, 0, 16'h2000, 0, 0);
    nxt();
    expect_out("rstmid_granted", 0, 1, 16'h4000, 0, 0);
    check("rstmid_granted_wdata", pmem_wdata, W5A);
    #2;
    rst = 1'b1;
    pmem_resp = 1'b1;
    expect_out("rstmid_async_drop", 0, 0, 16'h0000, 0, 0);
    check("rstmid_async_wdata", pmem_wdata, Z);
    nxt();
    rst = 1'b0; pmem_resp = 1'b0;
    d_pmem_write = 1'b0; d_pmem_read = 1'b1; d_pmem_address = 16'h4100;
    expect_out("rstmid_release", 0, 0, 16'h0000, 0, 0);
    nxt();
    expect_out("fresh_d_read", 1, 0, 16'h4100, 0, 0);
    nxt();
    pmem_resp = 1'b1; pmem_rdata = LE;
    expect_out("fresh_d_resp", 1, 0, 16'h4100, 0, 1);
    check("fresh_d_rdata", d_pmem_rdata, LE);
    nxt();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    expect_out("fresh_turn", 0, 0, 16'h4100, 0, 0);

    // Two simultaneous pairs right after reset: first goes to D; the second
    // goes to I only when alternating priority is built in.
`ifdef CACHE_ARB_RR_EN
    pair2_pa = 16'h0050; pair2_i = 1'b1;
`else
    pair2_pa = 16'h0070; pair2_i = 1'b0;
`endif
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0050;
    d_pmem_read = 1'b1; d_pmem_address = 16'h0060;
    expect_out("pair_idle", 0, 0, 16'h0000, 0, 0);
    nxt();
    expect_out("pair1_grant_d", 1, 0, 16'h0060, 0, 0);
    nxt();
    pmem_resp = 1'b1;
    expect_out("pair1_resp", 1, 0, 16'h0060, 0, 1);
    nxt();
    pmem_resp = 1'b0; d_pmem_read = 1'b0;
    expect_out("pair1_turn", 0, 0, 16'h0060, 0, 0);
    nxt();
    d_pmem_read = 1'b1; d_pmem_address = 16'h0070;
    expect_out("pair2_idle", 0, 0, 16'h0060, 0, 0);
    nxt();
    expect_out("pair2_grant", 1, 0, pair2_pa, 0, 0);
    nxt();
    pmem_resp = 1'b1;
    expect_out("pair2_resp", 1, 0, pair2_pa, pair2_i, ~pair2_i);
    nxt();
    pmem_resp = 1'b0; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    expect_out("pair2_turn", 0, 0, pair2_pa, 0, 0);

    // D read and write together are serviced as a write.
    nxt();
    d_pmem_read = 1'b1; d_pmem_write = 1'b1; d_pmem_address = 16'h0900; d_pmem_wdata = WC3;
    expect_out("rw_idle", 0, 0, pair2_pa, 0, 0);
    nxt();
    expect_out("rw_as_write", 0, 1, 16'h0900, 0, 0);
    check("rw_as_write_wdata", pmem_wdata, WC3);
    nxt();
    pmem_resp = 1'b1;
    expect_out("rw_resp", 0, 1, 16'h0900, 0, 1);
    nxt();
    pmem_resp = 1'b0; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    expect_out("rw_turn", 0, 0, 16'h0900, 0, 0);
    nxt();
    expect_out("rw_idle2", 0, 0, 16'h0900, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_cache_arbiter
